// File: rtl/morse_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_pkg                                                                |
// | Shared letter codes, symbol values, run lengths and FSM encoding for the |
// | Morse letter decoder.                                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package morse_pkg;

   localparam logic [2:0] LETTER_A = 3'd0;
   localparam logic [2:0] LETTER_B = 3'd1;
   localparam logic [2:0] LETTER_C = 3'd2;
   localparam logic [2:0] LETTER_D = 3'd3;
   localparam logic [2:0] LETTER_E = 3'd4;
   localparam logic [2:0] LETTER_F = 3'd5;
   localparam logic [2:0] LETTER_G = 3'd6;
   localparam logic [2:0] LETTER_H = 3'd7;

   localparam logic       SYM_DOT  = 1'b0;
   localparam logic       SYM_DASH = 1'b1;

   localparam logic [2:0] MAX_SYMBOLS = 3'd4;
   localparam logic [2:0] DOT_LEN     = 3'd1;
   localparam logic [2:0] DASH_LEN    = 3'd3;
   localparam logic [2:0] MARK_SAT    = 3'd4;
   localparam logic [1:0] LETTER_GAP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MARK   = 2'd1,
      ST_SPACE  = 2'd2,
      ST_DECODE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/morse_symbol_lookup.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_symbol_lookup                                                      |
// | Maps a symbol count and MSB-first dot/dash pattern to a letter A-H.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module morse_symbol_lookup
   import morse_pkg::*;
(
   input  logic [2:0] i_sym_cnt,
   input  logic [3:0] i_pattern,
   output logic [2:0] o_letter,
   output logic       o_match
);

   // The pattern is right-aligned: only the low i_sym_cnt bits are significant.
   always_comb begin
      o_letter = LETTER_A;
      o_match  = 1'b0;
      case (i_sym_cnt)
         3'd1: begin
            if (i_pattern[0] == SYM_DOT) begin
               o_letter = LETTER_E;
               o_match  = 1'b1;
            end
         end
         3'd2: begin
            if (i_pattern[1:0] == 2'b01) begin
               o_letter = LETTER_A;
               o_match  = 1'b1;
            end
         end
         3'd3: begin
            case (i_pattern[2:0])
               3'b100:  begin o_letter = LETTER_D; o_match = 1'b1; end
               3'b110:  begin o_letter = LETTER_G; o_match = 1'b1; end
               default: ;
            endcase
         end
         3'd4: begin
            case (i_pattern)
               4'b1000: begin o_letter = LETTER_B; o_match = 1'b1; end
               4'b1010: begin o_letter = LETTER_C; o_match = 1'b1; end
               4'b0010: begin o_letter = LETTER_F; o_match = 1'b1; end
               4'b0000: begin o_letter = LETTER_H; o_match = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_decoder                                                            |
// | Run-length decodes a strobed dot/dash line into letters A-H.             |
// | Optional error pulse output enabled by MORSE_DECODER_ERROR_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module morse_decoder
   import morse_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
   input  logic       ClockIn,
   input  logic       Resetn,
   input  logic       DotDashIn,
   input  logic       NewBitIn,
   output logic [2:0] LetterOut,
   output logic       LetterValid,
   output logic       ErrorOut
);

   localparam logic [30:0] c_idle_last = 31'(TIMEOUT_CYCLES - 1);

   state_t      r_state,      w_state;
   logic [2:0]  r_mark_cnt,   w_mark_cnt;
   logic [1:0]  r_space_cnt,  w_space_cnt;
   logic [3:0]  r_pattern,    w_pattern;
   logic [2:0]  r_sym_cnt,    w_sym_cnt;
   logic        r_bad,        w_bad;
   logic [30:0] r_idle,       w_idle;
   logic        r_pend_valid, w_pend_valid;
   logic [2:0]  r_pend_letter;
   logic        w_busy, w_expire, w_run_end;
   logic [2:0]  w_letter;
   logic        w_match;
`ifdef MORSE_DECODER_ERROR_EN
   logic        r_pend_error, w_pend_error;
`endif

   morse_symbol_lookup u_lookup (
      .i_sym_cnt (r_sym_cnt),
      .i_pattern (r_pattern),
      .o_letter  (w_letter),
      .o_match   (w_match)
   );

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         r_state       <= ST_IDLE;
         r_mark_cnt    <= '0;
         r_space_cnt   <= '0;
         r_pattern     <= '0;
         r_sym_cnt     <= '0;
         r_bad         <= 1'b0;
         r_idle        <= '0;
         r_pend_valid  <= 1'b0;
         r_pend_letter <= '0;
         LetterOut     <= '0;
         LetterValid   <= 1'b0;
`ifdef MORSE_DECODER_ERROR_EN
         r_pend_error  <= 1'b0;
         ErrorOut      <= 1'b0;
`endif
      end else begin
         r_state       <= w_state;
         r_mark_cnt    <= w_mark_cnt;
         r_space_cnt   <= w_space_cnt;
         r_pattern     <= w_pattern;
         r_sym_cnt     <= w_sym_cnt;
         r_bad         <= w_bad;
         r_idle        <= w_idle;
         r_pend_valid  <= w_pend_valid;
         r_pend_letter <= w_letter;
         LetterValid   <= r_pend_valid;
         if (r_pend_valid) begin
            LetterOut <= r_pend_letter;
         end
`ifdef MORSE_DECODER_ERROR_EN
         r_pend_error  <= w_pend_error;
         ErrorOut      <= r_pend_error;
`endif
      end
   end

`ifndef MORSE_DECODER_ERROR_EN
   assign ErrorOut = 1'b0;
`endif

   always_comb begin
      w_state      = r_state;
      w_mark_cnt   = r_mark_cnt;
      w_space_cnt  = r_space_cnt;
      w_pattern    = r_pattern;
      w_sym_cnt    = r_sym_cnt;
      w_bad        = r_bad;
      w_pend_valid = 1'b0;
      w_run_end    = 1'b0;
`ifdef MORSE_DECODER_ERROR_EN
      w_pend_error = 1'b0;
`endif
      // Idle counter only advances mid-letter; any strobe resets it and wins over expiry.
      w_busy   = (r_state == ST_MARK) || (r_state == ST_SPACE);
      w_expire = w_busy && !NewBitIn && (r_idle == c_idle_last);
      w_idle   = (w_busy && !NewBitIn) ? r_idle + 31'd1 : '0;

      case (r_state)
         ST_IDLE: begin
            if (NewBitIn && DotDashIn) begin
               w_state    = ST_MARK;
               w_mark_cnt = 3'd1;
               w_sym_cnt  = '0;
               w_pattern  = '0;
               w_bad      = 1'b0;
            end
         end
         ST_MARK: begin
            if (NewBitIn) begin
               if (DotDashIn) begin
                  if (r_mark_cnt != MARK_SAT) begin
                     w_mark_cnt = r_mark_cnt + 3'd1;
                  end
               end else begin
                  w_run_end   = 1'b1;
                  w_state     = ST_SPACE;
                  w_space_cnt = 2'd1;
               end
            end else if (w_expire) begin
               w_run_end = 1'b1;
               w_state   = ST_DECODE;
            end
         end
         ST_SPACE: begin
            if (NewBitIn) begin
               if (!DotDashIn) begin
                  w_space_cnt = r_space_cnt + 2'd1;
                  if (w_space_cnt == LETTER_GAP) begin
                     w_state = ST_DECODE;
                  end
               end else begin
                  if (r_space_cnt == 2'd2) begin
                     w_bad = 1'b1;
                  end
                  w_state    = ST_MARK;
                  w_mark_cnt = 3'd1;
               end
            end else if (w_expire) begin
               w_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_state      = ST_IDLE;
            w_pend_valid = !r_bad && w_match;
`ifdef MORSE_DECODER_ERROR_EN
            w_pend_error = r_bad || !w_match;
`endif
         end
         default: w_state = ST_IDLE;
      endcase

      // A finished mark run becomes one symbol; a fifth symbol only marks the letter bad.
      if (w_run_end) begin
         if ((r_mark_cnt != DOT_LEN) && (r_mark_cnt != DASH_LEN)) begin
            w_bad = 1'b1;
         end
         if (r_sym_cnt == MAX_SYMBOLS) begin
            w_bad = 1'b1;
         end else begin
            w_pattern = {r_pattern[2:0], (r_mark_cnt == DASH_LEN) ? SYM_DASH : SYM_DOT};
            w_sym_cnt = r_sym_cnt + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_morse_decoder                                                         |
// | Self-checking bench: directed letters plus random streams vs a           |
// | run-length reference model. Honours MORSE_DECODER_ERROR_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_morse_decoder;

   localparam int TO      = 20;
   localparam int EV_ERR  = 8;

   logic       ClockIn = 1'b0;
   logic       Resetn  = 1'b0;
   logic       DotDashIn = 1'b0;
   logic       NewBitIn  = 1'b0;
   logic [2:0] LetterOut;
   logic       LetterValid;
   logic       ErrorOut;

   int n_tests = 0;
   int n_fail  = 0;

   bit    stim[$];
   int    exp_q[$];
   int    obs_q[$];
   string morse_tab[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

   morse_decoder #(
      .CLOCK_FREQUENCY (TO),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .ClockIn     (ClockIn),
      .Resetn      (Resetn),
      .DotDashIn   (DotDashIn),
      .NewBitIn    (NewBitIn),
      .LetterOut   (LetterOut),
      .LetterValid (LetterValid),
      .ErrorOut    (ErrorOut)
   );

   always #5 ClockIn = ~ClockIn;

   always @(negedge ClockIn) begin
      if (LetterValid && ErrorOut) begin
         n_tests++;
         n_fail++;
         $display("FAIL exclusivity: LetterValid=%b ErrorOut=%b both high", LetterValid, ErrorOut);
      end
      if (LetterValid) obs_q.push_back(int'(LetterOut));
      if (ErrorOut)    obs_q.push_back(EV_ERR);
   end

   // One bit period = 4 cycles; line is noise while the strobe is low.
   task automatic strobe(input bit b);
      @(negedge ClockIn);
      NewBitIn  = 1'b1;
      DotDashIn = b;
      @(negedge ClockIn);
      NewBitIn  = 1'b0;
      DotDashIn = 1'($urandom);
      repeat (2) begin
         @(negedge ClockIn);
         DotDashIn = 1'($urandom);
      end
   endtask

   task automatic push_letter(input int code);
      string s;
      s = morse_tab[code];
      for (int c = 0; c < s.len(); c++) begin
         if (c > 0) stim.push_back(1'b0);
         if (s[c] == "-") repeat (3) stim.push_back(1'b1);
         else stim.push_back(1'b1);
      end
   endtask

   task automatic close_letter(input string syms, input bit bad);
      int code;
      code = EV_ERR;
      if (!bad && syms.len() <= 4)
         foreach (morse_tab[k]) if (syms == morse_tab[k]) code = k;
      if (code != EV_ERR) exp_q.push_back(code);
`ifdef MORSE_DECODER_ERROR_EN
      else exp_q.push_back(EV_ERR);
`endif
   endtask

   // Reference: split the bit stream into runs; marks become symbols, a 3-space gap
   // or the end of the stream (timeout) closes the letter.
   task automatic model_stim();
      int    i, n, len;
      bit    b, in_letter, bad;
      string syms;
      exp_q.delete();
      i = 0; n = stim.size(); in_letter = 0; bad = 0; syms = "";
      while (i < n) begin
         b = stim[i]; len = 0;
         while (i < n && stim[i] == b) begin len++; i++; end
         if (b) begin
            if (!in_letter) begin in_letter = 1; bad = 0; syms = ""; end
            if (len == 1)      syms = {syms, "."};
            else if (len == 3) syms = {syms, "-"};
            else begin bad = 1; syms = {syms, "?"}; end
         end else if (in_letter) begin
            if (len >= 3) begin close_letter(syms, bad); in_letter = 0; end
            else if (len == 2 && i < n) bad = 1;
         end
      end
      if (in_letter) close_letter(syms, bad);
   endtask

   task automatic play_stim();
      model_stim();
      foreach (stim[k]) strobe(stim[k]);
      repeat (TO + 12) @(negedge ClockIn);
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      repeat (3) @(negedge ClockIn);
      n_tests++;
      if (LetterOut !== 3'b000) begin n_fail++; $display("FAIL reset_letter: got %b expected 000", LetterOut); end
      n_tests++;
      if (LetterValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", LetterValid); end
      n_tests++;
      if (ErrorOut !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", ErrorOut); end
      Resetn = 1'b1;
      repeat (2) @(negedge ClockIn);
   endtask

   task automatic test_letter_a();
      bit head[7] = '{1, 0, 1, 1, 1, 0, 0};
      obs_q.delete();
      foreach (head[k]) strobe(head[k]);
      @(negedge ClockIn);
      NewBitIn = 1'b1; DotDashIn = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge ClockIn);
         NewBitIn = 1'b0;
         n_tests++;
         if (LetterValid !== (k == 3)) begin
            n_fail++; $display("FAIL a_valid_timing[+%0d]: got %b expected %b", k, LetterValid, (k == 3));
         end
         n_tests++;
         if (ErrorOut !== 1'b0) begin n_fail++; $display("FAIL a_error[+%0d]: got %b expected 0", k, ErrorOut); end
         if (k == 3) begin
            n_tests++;
            if (LetterOut !== 3'b000) begin n_fail++; $display("FAIL a_letter: got %b expected 000", LetterOut); end
         end
      end
      repeat (TO + 8) @(negedge ClockIn);
      n_tests++;
      if (obs_q.size() !== 1) begin n_fail++; $display("FAIL a_count: got %0d events expected 1", obs_q.size()); end
   endtask

   task automatic test_timeout_c();
      bit head[11] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1};
      obs_q.delete();
      foreach (head[k]) strobe(head[k]);
      @(negedge ClockIn);
      NewBitIn = 1'b1; DotDashIn = 1'b0;
      for (int k = 1; k <= TO + 6; k++) begin
         @(negedge ClockIn);
         NewBitIn = 1'b0;
         DotDashIn = 1'($urandom);
         n_tests++;
         if (LetterValid !== (k == TO + 3)) begin
            n_fail++; $display("FAIL c_valid_timing[+%0d]: got %b expected %b", k, LetterValid, (k == TO + 3));
         end
         if (k == TO + 3) begin
            n_tests++;
            if (LetterOut !== 3'b010) begin n_fail++; $display("FAIL c_letter: got %b expected 010", LetterOut); end
         end
      end
      repeat (6) @(negedge ClockIn);
      n_tests++;
      if (obs_q.size() !== 1) begin n_fail++; $display("FAIL c_count: got %0d events expected 1", obs_q.size()); end
   endtask

   task automatic test_bad_mark();
      stim = '{1, 1, 0, 0, 0};
      obs_q.delete();
      play_stim();
      n_tests++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL bad_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[k]) begin
         n_tests++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bad_event[%0d]: got %0d expected %0d", k, obs_q[k], exp_q[k]); end
      end
      n_tests++;
      if (LetterOut !== 3'b010) begin n_fail++; $display("FAIL bad_hold: got %b expected 010", LetterOut); end
   endtask

   task automatic test_overflow();
      stim.delete();
      repeat (5) begin stim.push_back(1); stim.push_back(0); end
      stim.push_back(0); stim.push_back(0);
      obs_q.delete();
      play_stim();
      n_tests++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ovf_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[k]) begin
         n_tests++;
         if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL ovf_event[%0d]: got %0d expected %0d", k, obs_q[k], exp_q[k]); end
      end
      n_tests++;
      if (LetterOut !== 3'b010) begin n_fail++; $display("FAIL ovf_hold: got %b expected 010", LetterOut); end
   endtask

   task automatic test_back_to_back();
      stim = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
      obs_q.delete();
      play_stim();
      n_tests++;
      if (obs_q.size() !== 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d events expected 2", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== 7) begin n_fail++; $display("FAIL b2b_first: got %0d expected 7", obs_q[0]); end
         n_tests++;
         if (obs_q[1] !== 4) begin n_fail++; $display("FAIL b2b_second: got %0d expected 4", obs_q[1]); end
      end
      n_tests++;
      if (LetterOut !== 3'b100) begin n_fail++; $display("FAIL b2b_final: got %b expected 100", LetterOut); end
   endtask

   task automatic test_reset_mid_letter();
      obs_q.delete();
      repeat (3) strobe(1'b1);
      @(negedge ClockIn);
      Resetn = 1'b0;
      #1;
      n_tests++;
      if (LetterOut !== 3'b000) begin n_fail++; $display("FAIL rst_async_letter: got %b expected 000", LetterOut); end
      repeat (2) @(negedge ClockIn);
      Resetn = 1'b1;
      stim = '{1, 0, 0, 0};
      play_stim();
      n_tests++;
      if (obs_q.size() !== 1) begin
         n_fail++; $display("FAIL rst_count: got %0d events expected 1", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== 4) begin n_fail++; $display("FAIL rst_letter: got %0d expected 4", obs_q[0]); end
      end
   endtask

   task automatic test_random();
      int nl, ns;
      for (int s = 0; s < 10; s++) begin
         stim.delete();
         obs_q.delete();
         nl = $urandom_range(1, 4);
         for (int l = 0; l < nl; l++) begin
            if ($urandom_range(0, 3) == 0) begin
               ns = $urandom_range(1, 6);
               for (int m = 0; m < ns; m++) begin
                  if (m > 0) repeat ($urandom_range(1, 2)) stim.push_back(1'b0);
                  repeat ($urandom_range(1, 5)) stim.push_back(1'b1);
               end
            end else begin
               push_letter($urandom_range(0, 7));
            end
            if (l < nl - 1 || $urandom_range(0, 1) == 1)
               repeat (3 + $urandom_range(0, 2)) stim.push_back(1'b0);
         end
         play_stim();
         n_tests++;
         if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count[%0d]: got %0d events expected %0d", s, obs_q.size(), exp_q.size());
         end else foreach (exp_q[k]) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL rand_event[%0d][%0d]: got %0d expected %0d", s, k, obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_letter_a();
      test_timeout_c();
      test_bad_mark();
      test_overflow();
      test_back_to_back();
      test_reset_mid_letter();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
